alarm_ctrl: RTL
===============

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SECONDS, default 60, shall set the number of second ticks an unanswered alarm rings before self-cancel (range 1..255).
REQ-002 Parameter SNOOZE_SECONDS, default 300, shall set the number of second ticks spent in snooze before re-ringing (range 1..1023).
REQ-003 Port clk  in  1  shall be the single system clock; all state changes on its rising edge.
REQ-004 Port rst_n  in  1  shall be the asynchronous, active-low reset.
REQ-005 Port sec_pulse  in  1  shall be the 1 Hz level signal from the seconds pulse generator; its rising edge, sampled in clk, is the "second tick".
REQ-006 Ports hour_h/hour_l/min_h/min_l/sec_h/sec_l  in  4 each  shall be the BCD current time from the time-counting chain.
REQ-007 Port alarm_en  in  1  shall be the alarm arm switch (level).
REQ-008 Ports set_min_btn, set_hour_btn, stop_btn, snooze_btn  in  1 each  shall be pre-debounced active-high buttons, acted on at their rising edge only.
REQ-009 Ports alm_hour_h/alm_hour_l/alm_min_h/alm_min_l  out  4 each  shall present the stored BCD alarm time for the display mux.
REQ-010 Port ringing  out  1  shall be high exactly while the state is RINGING.
REQ-011 Port buzzer  out  1  shall be ringing AND sec_pulse (1 Hz beep), registered.
REQ-012 Port snoozing  out  1  shall be high exactly while the state is SNOOZE.
REQ-013 Port chime  out  1  shall be the hourly chime pulse.

Function
REQ-014 Edge detection shall register each button and sec_pulse once and produce a one-clk pulse on 0->1; latency from input edge to pulse is one clk.
REQ-015 set_min_btn pulse shall increment the alarm minute in BCD: low digit 9->0 carries to high; 59 wraps to 00 without touching the alarm hour.
REQ-016 set_hour_btn pulse shall increment the alarm hour in BCD: 09->10, 19->20, 23 wraps to 00.
REQ-017 Simultaneous set_min and set_hour pulses shall both be applied in the same cycle.
REQ-018 Match shall be true when hour_h:hour_l:min_h:min_l equals the alarm time and sec_h=0, sec_l=0.
REQ-019 FSM states: IDLE, RINGING, SNOOZE; encoding per shared package.
REQ-020 IDLE -> RINGING on a second tick with match and alarm_en=1; ring counter cleared.
REQ-021 RINGING: each second tick increments the ring counter; reaching RING_SECONDS -> IDLE.
REQ-022 RINGING -> IDLE on stop pulse; RINGING -> SNOOZE on snooze pulse, snooze counter cleared; stop wins if both pulse in the same cycle.
REQ-023 SNOOZE: each second tick increments the snooze counter; reaching SNOOZE_SECONDS -> RINGING with ring counter cleared; stop pulse -> IDLE.
REQ-024 alarm_en=0 shall force IDLE on the next clk from any state.
REQ-025 A match occurring while in RINGING or SNOOZE shall be ignored (no counter restart).
REQ-026 Changing the alarm time while RINGING or SNOOZE shall not alter the current state.
REQ-027 chime shall go high for one full second (from the tick where min=00 and sec=00 to the next tick) independent of alarm_en, and shall be suppressed while ringing=1.

Reset
REQ-028 rst_n low shall asynchronously force: state IDLE, alarm time 00:00, all counters 0, edge-detect registers 0, ringing/buzzer/snoozing/chime 0.
REQ-029 Reset release mid-operation shall resume in IDLE; no spurious edge pulses on the first clk after release even if inputs are high (edge registers load inputs on first clk only).

Structure
REQ-030 Shared package alarm_pkg shall hold the state encoding constants and BCD limit constants (9, 5, 2, 3).
REQ-031 Rising-edge detection shall be a sub-module edge_pulse, instantiated once per sampled input (five instances).
REQ-032 Ring and snooze counters shall be sized from their parameters; no other sub-modules.

Verification
REQ-033 Reset, press set_hour_btn 7 times, set_min_btn 30 times -> alm outputs 0,7,3,0.
REQ-034 Alarm 07:30, alarm_en=1, drive 07:29:59 then tick to 07:30:00 -> ringing=1 one clk after the tick; buzzer follows sec_pulse; after 60 ticks ringing=0.
REQ-035 While ringing, assert stop_btn and snooze_btn in the same clk -> IDLE, snoozing=0.
REQ-036 While ringing, snooze_btn -> snoozing=1; after 300 ticks ringing=1 again; stop_btn then -> IDLE.
REQ-037 Alarm at 23:59, press set_min_btn then set_hour_btn together -> 00:00; time 10:00:00 tick -> chime=1 for exactly one second.
REQ-038 Assert rst_n low while RINGING with buttons held high -> all outputs 0 immediately, no action after release until a fresh button edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: FSM state encoding and BCD digit limits.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ONES_MAX          = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX          = 4'd5;
  localparam logic [3:0] HOUR_TENS_MAX         = 4'd2;
  localparam logic [3:0] HOUR_ONES_AT_TENS_MAX = 4'd3;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-clk pulse on a 0->1 transition of din.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_q;
  logic armed;

  // The first clk after reset only loads din, so inputs already high never fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      din_q <= din;
      armed <= 1'b1;
    end
  end

  assign pulse = armed & din & ~din_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm-time setting, ring/snooze FSM, 1 Hz buzzer and hourly chime.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_pulse,
  input  logic [3:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  input  logic       alarm_en,
  input  logic       set_min_btn,
  input  logic       set_hour_btn,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic [3:0] alm_hour_h,
  output logic [3:0] alm_hour_l,
  output logic [3:0] alm_min_h,
  output logic [3:0] alm_min_l,
  output logic       ringing,
  output logic       buzzer,
  output logic       snoozing,
  output logic       chime
);

  localparam int RING_W   = $clog2(RING_SECONDS + 1);
  localparam int SNOOZE_W = $clog2(SNOOZE_SECONDS + 1);
  localparam logic [RING_W-1:0]   RING_LAST   = RING_W'(RING_SECONDS - 1);
  localparam logic [SNOOZE_W-1:0] SNOOZE_LAST = SNOOZE_W'(SNOOZE_SECONDS - 1);

  logic sec_tick, min_press, hour_press, stop_press, snooze_press;
  logic match, top_of_hour, chime_on;
  state_t state;
  logic [RING_W-1:0]   ring_cnt;
  logic [SNOOZE_W-1:0] snooze_cnt;

  edge_pulse u_sec    (.clk(clk), .rst_n(rst_n), .din(sec_pulse),    .pulse(sec_tick));
  edge_pulse u_min    (.clk(clk), .rst_n(rst_n), .din(set_min_btn),  .pulse(min_press));
  edge_pulse u_hour   (.clk(clk), .rst_n(rst_n), .din(set_hour_btn), .pulse(hour_press));
  edge_pulse u_stop   (.clk(clk), .rst_n(rst_n), .din(stop_btn),     .pulse(stop_press));
  edge_pulse u_snooze (.clk(clk), .rst_n(rst_n), .din(snooze_btn),   .pulse(snooze_press));

  assign match = (hour_h == alm_hour_h) && (hour_l == alm_hour_l) &&
                 (min_h == alm_min_h) && (min_l == alm_min_l) &&
                 (sec_h == 4'd0) && (sec_l == 4'd0);
  assign top_of_hour = (min_h == 4'd0) && (min_l == 4'd0) && (sec_h == 4'd0) && (sec_l == 4'd0);

  // Minute and hour increments are independent so simultaneous presses both apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alm_hour_h <= 4'd0;
      alm_hour_l <= 4'd0;
      alm_min_h  <= 4'd0;
      alm_min_l  <= 4'd0;
    end else begin
      if (min_press) begin
        if (alm_min_l == BCD_ONES_MAX) begin
          alm_min_l <= 4'd0;
          alm_min_h <= (alm_min_h == MIN_TENS_MAX) ? 4'd0 : alm_min_h + 4'd1;
        end else begin
          alm_min_l <= alm_min_l + 4'd1;
        end
      end
      if (hour_press) begin
        if (alm_hour_h == HOUR_TENS_MAX && alm_hour_l == HOUR_ONES_AT_TENS_MAX) begin
          alm_hour_h <= 4'd0;
          alm_hour_l <= 4'd0;
        end else if (alm_hour_l == BCD_ONES_MAX) begin
          alm_hour_h <= alm_hour_h + 4'd1;
          alm_hour_l <= 4'd0;
        end else begin
          alm_hour_l <= alm_hour_l + 4'd1;
        end
      end
    end
  end

  // Stop has priority over snooze; a match outside IDLE never restarts the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      buzzer     <= 1'b0;
      chime_on   <= 1'b0;
    end else begin
      buzzer <= ringing & sec_pulse;
      if (sec_tick) chime_on <= top_of_hour;
      if (!alarm_en) begin
        state    <= ST_IDLE;
        ringing  <= 1'b0;
        snoozing <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sec_tick && match) begin
              state    <= ST_RINGING;
              ring_cnt <= '0;
              ringing  <= 1'b1;
            end
          end
          ST_RINGING: begin
            if (stop_press) begin
              state   <= ST_IDLE;
              ringing <= 1'b0;
            end else if (snooze_press) begin
              state      <= ST_SNOOZE;
              snooze_cnt <= '0;
              ringing    <= 1'b0;
              snoozing   <= 1'b1;
            end else if (sec_tick) begin
              if (ring_cnt == RING_LAST) begin
                state   <= ST_IDLE;
                ringing <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt + 1'b1;
              end
            end
          end
          ST_SNOOZE: begin
            if (stop_press) begin
              state    <= ST_IDLE;
              snoozing <= 1'b0;
            end else if (sec_tick) begin
              if (snooze_cnt == SNOOZE_LAST) begin
                state    <= ST_RINGING;
                ring_cnt <= '0;
                ringing  <= 1'b1;
                snoozing <= 1'b0;
              end else begin
                snooze_cnt <= snooze_cnt + 1'b1;
              end
            end
          end
          default: begin
            state    <= ST_IDLE;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign chime = chime_on & ~ringing;

endmodule
